// File: rtl/coin_acceptor.sv
// -----------------------------------------------------------------------------
// coin_acceptor
//
// Front end of the vending machine controller. Cleans up the two bouncy
// coin-slot sensors and hands the vending FSM fixed-width, registered
// coin1 / coin2 pulses. Coins that cannot be taken are answered with a
// one-cycle reject pulse, which opens the return chute. A coin cannot be taken
// when the downstream FSM is not ready, when both coins land in the same
// cycle, or when an accept cycle is still in progress.
//
// Parameters
//   DEBOUNCE_CYCLES  stable synchronized samples needed to change a level (>=2)
//   PULSE_CYCLES     width of each coin1 / coin2 pulse in cycles (>=1)
//   LOCKOUT_CYCLES   minimum quiet cycles after a pulse before the next accept
//                    (>=1)
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active low
//   coin1_raw  asynchronous small-coin sensor, 1 = coin present
//   coin2_raw  asynchronous large-coin sensor, 1 = coin present
//   enable     1 = downstream can take a coin
//   coin1      accepted small coin, high for PULSE_CYCLES
//   coin2      accepted large coin, high for PULSE_CYCLES
//   reject     one-cycle pulse, coin not credited
//   busy       1 while an accept cycle (pulse + lockout) is in progress
// -----------------------------------------------------------------------------
module coin_acceptor #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int PULSE_CYCLES    = 2,
   parameter int LOCKOUT_CYCLES  = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic coin1_raw,
   input  logic coin2_raw,
   input  logic enable,
   output logic coin1,
   output logic coin2,
   output logic reject,
   output logic busy
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int PW = (PULSE_CYCLES   > 1) ? $clog2(PULSE_CYCLES)   : 1;
   localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

   localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
   localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCKOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PULSE   = 2'd1,
      ST_LOCKOUT = 2'd2
   } state_t;

   typedef enum logic {
      COIN_SMALL = 1'b0,
      COIN_LARGE = 1'b1
   } coin_t;

   // Index 0 is the small-coin line, index 1 the large-coin line.
   logic [1:0]    raw;
   logic [1:0]    sync_meta;
   logic [1:0]    sync;
   logic [1:0]    deb;
   logic [1:0]    deb_prev;
   logic [DW-1:0] deb_cnt [2];
   logic [1:0]    rise;

   state_t        state_q,  state_next;
   coin_t         type_q,   type_next;
   logic [PW-1:0] pcnt_q,   pcnt_next;
   logic [LW-1:0] lcnt_q,   lcnt_next;
   logic          reject_next;

   assign raw = {coin2_raw, coin1_raw};

   // ---------------------------------------------------------------------------
   // Synchronizers, debouncers and rise detection
   // ---------------------------------------------------------------------------
   // NOTE: rst is sampled on the clock edge (synchronous reset), so it is only
   // tested inside the clocked block and never appears in the sensitivity list.
   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of its neighbours, which the two-flop synchronizer
   // chain depends on.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_meta <= '0;
         sync      <= '0;
         deb       <= '0;
         deb_prev  <= '0;
         for (int i = 0; i < 2; i++) begin
            deb_cnt[i] <= '0;
         end
      end else begin
         sync_meta <= raw;
         sync      <= sync_meta;
         deb_prev  <= deb;
         for (int i = 0; i < 2; i++) begin
            if (sync[i] != deb[i]) begin
               // Level differs: count agreement, commit on the last sample.
               if (deb_cnt[i] == DEB_LAST) begin
                  deb[i]     <= sync[i];
                  deb_cnt[i] <= '0;
               end else begin
                  deb_cnt[i] <= deb_cnt[i] + 1'b1;
               end
            end else begin
               // Any sample matching the current level restarts the count,
               // so short glitches never reach the debounced level.
               deb_cnt[i] <= '0;
            end
         end
      end
   end

   // Only rising edges are events; removing a coin is silent.
   assign rise = deb & ~deb_prev;

   // ---------------------------------------------------------------------------
   // Accept / reject FSM, next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: every variable gets a default at the top of the block so no path
   // leaves one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_next  = state_q;
      type_next   = type_q;
      pcnt_next   = pcnt_q;
      lcnt_next   = lcnt_q;
      reject_next = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (|rise) begin
               if ((&rise) || !enable) begin
                  reject_next = 1'b1;
               end else begin
                  state_next = ST_PULSE;
                  type_next  = rise[1] ? COIN_LARGE : COIN_SMALL;
                  pcnt_next  = '0;
               end
            end
         end

         ST_PULSE: begin
            // A coin arriving mid-pulse is returned; the pulse runs on.
            reject_next = |rise;
            if (pcnt_q == PULSE_LAST) begin
               state_next = ST_LOCKOUT;
               lcnt_next  = '0;
            end else begin
               pcnt_next = pcnt_q + 1'b1;
            end
         end

         ST_LOCKOUT: begin
            reject_next = |rise;
            // Both sensors must be clear to leave, so a stuck sensor parks the
            // block here instead of producing a second credit.
            if ((lcnt_q >= LOCK_LAST) && (deb == 2'b00)) begin
               state_next = ST_IDLE;
            end else if (lcnt_q < LOCK_LAST) begin
               lcnt_next = lcnt_q + 1'b1;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State and registered outputs
   // ---------------------------------------------------------------------------
   // Outputs are decoded from the next state so they line up with the state
   // register: coin1 / coin2 / busy rise on the same edge the FSM enters PULSE.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         type_q  <= COIN_SMALL;
         pcnt_q  <= '0;
         lcnt_q  <= '0;
         coin1   <= 1'b0;
         coin2   <= 1'b0;
         reject  <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state_q <= state_next;
         type_q  <= type_next;
         pcnt_q  <= pcnt_next;
         lcnt_q  <= lcnt_next;
         coin1   <= (state_next == ST_PULSE) && (type_next == COIN_SMALL);
         coin2   <= (state_next == ST_PULSE) && (type_next == COIN_LARGE);
         reject  <= reject_next;
         busy    <= (state_next != ST_IDLE);
      end
   end

endmodule

// File: tb/tb_coin_acceptor.sv
// -----------------------------------------------------------------------------
// tb_coin_acceptor
//
// Directed bench for coin_acceptor at default parameters. Inputs are driven
// 1 time unit after a rising edge and outputs are sampled at the same point,
// so "after edge N" below means the settled value following rising edge N,
// where edge N is the first edge that samples a newly raised sensor.
// -----------------------------------------------------------------------------
module tb_coin_acceptor;

   logic clk;
   logic rst;
   logic coin1_raw;
   logic coin2_raw;
   logic enable;
   logic coin1;
   logic coin2;
   logic reject;
   logic busy;

   int pass_cnt  = 0;
   int total_cnt = 0;

   // Running counts of high output cycles, sampled on the falling edge.
   int c1_hi   = 0;
   int c2_hi   = 0;
   int rej_hi  = 0;
   int both_hi = 0;
   int c1_base, c2_base, rej_base;

   coin_acceptor dut (
      .clk       (clk),
      .rst       (rst),
      .coin1_raw (coin1_raw),
      .coin2_raw (coin2_raw),
      .enable    (enable),
      .coin1     (coin1),
      .coin2     (coin2),
      .reject    (reject),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (coin1 === 1'b1) c1_hi++;
      if (coin2 === 1'b1) c2_hi++;
      if (reject === 1'b1) rej_hi++;
      if ((coin1 === 1'b1) && (coin2 === 1'b1)) both_hi++;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic obs, input logic exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic snapshot();
      c1_base  = c1_hi;
      c2_base  = c2_hi;
      rej_base = rej_hi;
   endtask

   initial begin
      rst       = 1'b0;
      coin1_raw = 1'b0;
      coin2_raw = 1'b0;
      enable    = 1'b1;

      // ---- reset state ----
      step(3);
      check("rst_coin1", coin1, 1'b0);
      check("rst_coin2", coin2, 1'b0);
      check("rst_reject", reject, 1'b0);
      check("rst_busy", busy, 1'b0);
      rst = 1'b1;
      step(4);

      // ---- 1: clean coin1 held 10 cycles ----
      snapshot();
      coin1_raw = 1'b1;
      step(1);                                   // edge N
      step(5);                                   // N+5
      check("t1_coin1_n5", coin1, 1'b0);
      check("t1_busy_n5", busy, 1'b0);
      step(1);                                   // N+6
      check("t1_coin1_n6", coin1, 1'b1);
      check("t1_busy_n6", busy, 1'b1);
      check("t1_reject_n6", reject, 1'b0);
      step(1);                                   // N+7
      check("t1_coin1_n7", coin1, 1'b1);
      step(1);                                   // N+8
      check("t1_coin1_n8", coin1, 1'b0);
      check("t1_busy_n8", busy, 1'b1);
      step(1);                                   // N+9, last high sample
      coin1_raw = 1'b0;
      step(6);                                   // N+15
      check("t1_busy_n15", busy, 1'b1);
      step(1);                                   // N+16
      check("t1_busy_n16", busy, 1'b0);
      check_int("t1_coin1_width", c1_hi - c1_base, 2);
      check_int("t1_reject_cnt", rej_hi - rej_base, 0);
      step(2);

      // ---- 2: 3-cycle glitch, then bounce, then steady coin2 ----
      snapshot();
      coin2_raw = 1'b1;
      step(3);
      coin2_raw = 1'b0;
      step(10);
      check_int("t2_glitch_coin2", c2_hi - c2_base, 0);
      check_int("t2_glitch_reject", rej_hi - rej_base, 0);
      check("t2_glitch_busy", busy, 1'b0);
      for (int i = 0; i < 6; i++) begin
         coin2_raw = (i % 2 == 0);
         step(1);
      end
      coin2_raw = 1'b1;
      step(1);                                   // edge N of steady run
      step(5);
      check("t2_coin2_n5", coin2, 1'b0);
      step(1);
      check("t2_coin2_n6", coin2, 1'b1);
      check("t2_coin1_n6", coin1, 1'b0);
      step(1);
      check("t2_coin2_n7", coin2, 1'b1);
      step(1);
      check("t2_coin2_n8", coin2, 1'b0);
      coin2_raw = 1'b0;
      step(20);
      check_int("t2_coin2_width", c2_hi - c2_base, 2);
      check_int("t2_reject_cnt", rej_hi - rej_base, 0);
      check("t2_busy_end", busy, 1'b0);

      // ---- 3: both coins on the same edge ----
      snapshot();
      coin1_raw = 1'b1;
      coin2_raw = 1'b1;
      step(6);                                   // N+5
      check("t3_reject_n5", reject, 1'b0);
      step(1);                                   // N+6
      check("t3_reject_n6", reject, 1'b1);
      check("t3_busy_n6", busy, 1'b0);
      step(1);                                   // N+7
      check("t3_reject_n7", reject, 1'b0);
      coin1_raw = 1'b0;
      coin2_raw = 1'b0;
      step(10);
      check_int("t3_coin1_cnt", c1_hi - c1_base, 0);
      check_int("t3_coin2_cnt", c2_hi - c2_base, 0);
      check_int("t3_reject_cnt", rej_hi - rej_base, 1);
      check("t3_busy_end", busy, 1'b0);

      // ---- 4: enable low, then a coin after enable returns ----
      snapshot();
      enable    = 1'b0;
      coin1_raw = 1'b1;
      step(7);                                   // N+6
      check("t4_reject_n6", reject, 1'b1);
      check("t4_coin1_n6", coin1, 1'b0);
      check("t4_busy_n6", busy, 1'b0);
      coin1_raw = 1'b0;
      step(10);
      enable = 1'b1;
      step(1);
      coin1_raw = 1'b1;
      step(7);                                   // N'+6
      check("t4_coin1_second", coin1, 1'b1);
      check("t4_reject_second", reject, 1'b0);
      coin1_raw = 1'b0;
      step(12);
      check_int("t4_coin1_width", c1_hi - c1_base, 2);
      check_int("t4_reject_cnt", rej_hi - rej_base, 1);
      check("t4_busy_end", busy, 1'b0);

      // ---- 5: coin2 arriving during lockout, then stuck ----
      snapshot();
      coin1_raw = 1'b1;
      step(5);                                   // N+4, last high sample
      coin1_raw = 1'b0;
      step(2);                                   // N+6
      check("t5_coin1_n6", coin1, 1'b1);
      step(1);                                   // N+7
      check("t5_coin1_n7", coin1, 1'b1);
      step(1);                                   // N+8
      check("t5_coin1_n8", coin1, 1'b0);
      step(1);                                   // N+9
      coin2_raw = 1'b1;                          // first sampled at N+10
      step(6);                                   // N+15
      check("t5_reject_n15", reject, 1'b0);
      step(1);                                   // N+16
      check("t5_reject_n16", reject, 1'b1);
      check("t5_coin2_n16", coin2, 1'b0);
      check("t5_busy_n16", busy, 1'b1);
      step(1);                                   // N+17
      check("t5_reject_n17", reject, 1'b0);
      coin2_raw = 1'b0;
      step(6);                                   // N+23, deb2 just fell
      check("t5_busy_n23", busy, 1'b1);
      step(1);                                   // N+24
      check("t5_busy_n24", busy, 1'b0);
      check_int("t5_coin1_width", c1_hi - c1_base, 2);
      check_int("t5_coin2_cnt", c2_hi - c2_base, 0);
      check_int("t5_reject_cnt", rej_hi - rej_base, 1);
      step(2);

      // ---- 6: reset in the second pulse cycle, coin held across release ----
      coin1_raw = 1'b1;
      step(7);                                   // N+6
      check("t6_coin1_n6", coin1, 1'b1);
      rst = 1'b0;
      step(1);                                   // N+7 with reset
      check("t6_rst_coin1", coin1, 1'b0);
      check("t6_rst_coin2", coin2, 1'b0);
      check("t6_rst_reject", reject, 1'b0);
      check("t6_rst_busy", busy, 1'b0);
      step(2);
      rst = 1'b1;
      step(1);                                   // edge R
      step(5);                                   // R+5
      check("t6_coin1_r5", coin1, 1'b0);
      step(1);                                   // R+6
      check("t6_coin1_r6", coin1, 1'b1);
      check("t6_busy_r6", busy, 1'b1);
      step(1);                                   // R+7
      check("t6_coin1_r7", coin1, 1'b1);
      step(1);                                   // R+8
      check("t6_coin1_r8", coin1, 1'b0);
      coin1_raw = 1'b0;
      step(20);
      check("t6_busy_end", busy, 1'b0);

      check_int("never_both_coins", both_hi, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
